// File: rtl/power_switch_ack_model.sv
// Behavioural model of the power-switch cells on power-gated domains: one ramp FSM per domain
// that returns a switch ack after a per-direction latency, with a sticky isolation-violation flag.
module power_switch_ack_model #(
    parameter int unsigned               NUM_DOMAINS = 4,
    parameter int unsigned               ON_LATENCY  = 15,
    parameter int unsigned               OFF_LATENCY = 15,
    parameter logic [NUM_DOMAINS-1:0]    RESET_STATE = '1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_DOMAINS-1:0] switch_i,
    input  logic [NUM_DOMAINS-1:0] iso_ni,
    output logic [NUM_DOMAINS-1:0] switch_ack_o,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [NUM_DOMAINS-1:0] iso_violation_o,
    input  logic                   violation_clear_i
);

    localparam int unsigned MAX_LAT = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] ON_CNT  = CNT_W'(ON_LATENCY);
    localparam logic [CNT_W-1:0] OFF_CNT = CNT_W'(OFF_LATENCY);

    typedef enum logic [1:0] {StOff, StRampOn, StOn, StRampOff} state_e;

    state_e                 state_q [NUM_DOMAINS];
    state_e                 state_d [NUM_DOMAINS];
    logic [CNT_W-1:0]       cnt_q   [NUM_DOMAINS];
    logic [CNT_W-1:0]       cnt_d   [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] ack_q, ack_d;
    logic [NUM_DOMAINS-1:0] busy_q, busy_d;
    logic [NUM_DOMAINS-1:0] viol_q, viol_d;

    always_comb begin
        ack_d  = '0;
        busy_d = '0;
        viol_d = '0;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            // A reversed request is checked before completion so an abort always wins.
            unique case (state_q[d])
                StOff: begin
                    if (switch_i[d]) begin
                        state_d[d] = StRampOn;
                        cnt_d[d]   = CNT_W'(1);
                    end
                end
                StRampOn: begin
                    if (!switch_i[d]) begin
                        state_d[d] = StOff;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] == ON_CNT) begin
                        state_d[d] = StOn;
                        cnt_d[d]   = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] + CNT_W'(1);
                    end
                end
                StOn: begin
                    if (!switch_i[d]) begin
                        state_d[d] = StRampOff;
                        cnt_d[d]   = CNT_W'(1);
                    end
                end
                StRampOff: begin
                    if (switch_i[d]) begin
                        state_d[d] = StOn;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] == OFF_CNT) begin
                        state_d[d] = StOff;
                        cnt_d[d]   = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] + CNT_W'(1);
                    end
                end
            endcase
            ack_d[d]  = (state_d[d] == StOn) || (state_d[d] == StRampOff);
            busy_d[d] = (state_d[d] == StRampOn) || (state_d[d] == StRampOff);
            // New violation takes priority over a coincident clear.
            viol_d[d] = (viol_q[d] & ~violation_clear_i) | (iso_ni[d] & (state_q[d] != StOn));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                state_q[d] <= RESET_STATE[d] ? StOn : StOff;
                cnt_q[d]   <= '0;
            end
            ack_q  <= RESET_STATE;
            busy_q <= '0;
            viol_q <= '0;
        end else begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
            ack_q  <= ack_d;
            busy_q <= busy_d;
            viol_q <= viol_d;
        end
    end

    assign switch_ack_o    = ack_q;
    assign busy_o          = busy_q;
    assign iso_violation_o = viol_q;

endmodule
